// File: rtl/pp_uart_pkg.sv
// pp_uart_pkg: shared constants, FSM encoding and helpers for the pp_uart
// transmitter and receiver.
package pp_uart_pkg;

    // Baud ticks per bit period; pp_uart_baud produces a 16x tick
    localparam int unsigned UART_OVS_DEFAULT = 16;

    // Frame data width defaults and limits
    localparam int unsigned UART_DW_DEFAULT  = 8;
    localparam int unsigned UART_DW_MAX      = 8;

    // Counter widths: tick counter covers OVS up to 16, bit counter covers DW up to 8
    localparam int unsigned TICK_CNT_W       = 4;
    localparam int unsigned BIT_CNT_W        = 4;

    // Serial frame FSM encoding, shared with the receiver
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Parity over a zero-extended data word; zero padding leaves the XOR unchanged
    function automatic logic uart_parity(input logic [UART_DW_MAX-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/pp_uart_bit_timer.sv
// pp_uart_bit_timer: counts baud ticks within one bit period and strobes the
// bit boundary (last tick) and the bit centre (used by the receiver to sample).
module pp_uart_bit_timer
    import pp_uart_pkg::*;
#(
    parameter int unsigned OVS = UART_OVS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic baud_clk,
    input  logic en,
    output logic bit_end,
    output logic bit_mid
);

    localparam logic [TICK_CNT_W-1:0] LastTick = TICK_CNT_W'(OVS - 1);
    localparam logic [TICK_CNT_W-1:0] MidTick  = TICK_CNT_W'(OVS / 2 - 1);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;
    logic                  tick;

    // A tick only counts while enabled and not being cleared
    assign tick = en && baud_clk && !clear;

    // Next tick count: wrap to zero on the last tick of a bit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == LastTick) ? '0 : cnt_q + TICK_CNT_W'(1);
        end
    end

    // Strobes are decoded from the count before the tick is applied
    always_comb begin
        bit_end = tick && (cnt_q == LastTick);
        bit_mid = tick && (cnt_q == MidTick);
    end

    // Tick counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pp_uart_tx.sv
// pp_uart_tx: UART transmit serializer. Accepts one word per valid/ready
// handshake and sends start, DW data bits LSB-first, optional parity and one
// or two stop bits on txd, timed by the 16x baud_clk tick from pp_uart_baud.
// Optional feature: define PP_UART_TX_PARITY_EN to add the parity_odd input
// and the parity bit.
module pp_uart_tx
    import pp_uart_pkg::*;
#(
    parameter int unsigned OVS = UART_OVS_DEFAULT,
    parameter int unsigned DW  = UART_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          soft_rst,
    input  logic          baud_clk,
    input  logic          stop2,
`ifdef PP_UART_TX_PARITY_EN
    input  logic          parity_odd,
`endif
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          txd
);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DW-1:0]        shift_q;
    logic [DW-1:0]        shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic                 stop2_q;
    logic                 stop2_d;
`ifdef PP_UART_TX_PARITY_EN
    logic                 par_q;
    logic                 par_d;
`endif
    logic                 txd_q;
    logic                 txd_d;
    logic                 done_q;
    logic                 done_d;

    logic                 xfer;
    logic                 bit_end;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 last_data;
    logic                 last_stop;
    logic                 unused_bit_mid;

    assign xfer      = tx_valid && tx_ready;
    assign last_data = (bit_cnt_q == BIT_CNT_W'(DW - 1));
    // Stop phase is counted in bit periods: one, or two when stop2 was latched
    assign last_stop = (bit_cnt_q == BIT_CNT_W'(stop2_q));

    // Timer is held at zero while idle so a tick in the transfer cycle is ignored
    assign timer_clear = !soft_rst || (state_q == StIdle);
    assign timer_en    = (state_q != StIdle);

    pp_uart_bit_timer #(
        .OVS (OVS)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .baud_clk (baud_clk),
        .en       (timer_en),
        .bit_end  (bit_end),
        .bit_mid  (unused_bit_mid)
    );

    // FSM state register; soft_rst aborts any frame in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else if (!soft_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: each non-idle phase ends on a bit boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && last_data) begin
`ifdef PP_UART_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end && last_stop) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: latch word and options on transfer, shift per data bit
    always_comb begin
        shift_d   = shift_q;
        stop2_d   = stop2_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PP_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (xfer) begin
            shift_d = tx_data;
            stop2_d = stop2;
`ifdef PP_UART_TX_PARITY_EN
            par_d   = uart_parity(UART_DW_MAX'(tx_data), parity_odd);
`endif
        end else if ((state_q == StData) && bit_end) begin
            shift_d = shift_q >> 1;
        end

        // Bit counter restarts at every phase change
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (bit_end) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            stop2_q   <= 1'b0;
            bit_cnt_q <= '0;
`ifdef PP_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (!soft_rst) begin
            shift_q   <= '0;
            stop2_q   <= 1'b0;
            bit_cnt_q <= '0;
`ifdef PP_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            stop2_q   <= stop2_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef PP_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Outputs: handshake/status from state, serial bit from the upcoming state
    always_comb begin
        tx_ready = (state_q == StIdle);
        tx_busy  = (state_q != StIdle);
        done_d   = (state_q == StStop) && (state_d == StIdle);
        txd_d    = 1'b1;
        unique case (state_d)
            StStart: begin
                txd_d = 1'b0;
            end
            StData: begin
                txd_d = shift_d[0];
            end
            StParity: begin
`ifdef PP_UART_TX_PARITY_EN
                txd_d = par_q;
`else
                txd_d = 1'b1;
`endif
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    // Registered serial line and end-of-frame pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (!soft_rst) begin
            txd_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            done_q <= done_d;
        end
    end

    assign txd     = txd_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_pp_uart_tx.sv
// tb_pp_uart_tx: self-checking bench for pp_uart_tx with a frame-list model.
module tb_pp_uart_tx;

    localparam int unsigned OVS     = 16;
    localparam int unsigned DW      = 8;
    localparam int          BIT_CYC = 64;  // OVS ticks, one tick every 4 clk
`ifdef PP_UART_TX_PARITY_EN
    localparam int          NB      = 11;
    localparam logic [15:0] EXP_A5  = 16'h054A;
    localparam logic [15:0] EXP_55  = 16'h04AA;
    localparam logic [15:0] EXP_3C  = 16'h0C78;
`else
    localparam int          NB      = 10;
    localparam logic [15:0] EXP_A5  = 16'h034A;
    localparam logic [15:0] EXP_55  = 16'h02AA;
    localparam logic [15:0] EXP_3C  = 16'h0678;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          soft_rst   = 1'b1;
    logic          baud_clk   = 1'b0;
    logic          stop2      = 1'b0;
    logic          parity_odd = 1'b0;
    logic [DW-1:0] tx_data    = '0;
    logic          tx_valid   = 1'b0;
    logic          tx_ready;
    logic          tx_busy;
    logic          tx_done;
    logic          txd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model state: remaining frame bits, ticks spent in the current bit
    bit   m_bits[$];
    bit   m_busy  = 1'b0;
    int   m_ticks = 0;
    logic e_txd   = 1'b1;
    logic e_done  = 1'b0;

    pp_uart_tx #(
        .OVS (OVS),
        .DW  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .baud_clk   (baud_clk),
        .stop2      (stop2),
`ifdef PP_UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    initial begin : cyc_count
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // One-cycle baud tick every 4 clk, changed 1 time unit after the edge
    initial begin : baud_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            baud_clk = (ph == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer queues the whole frame as bits, each lasting OVS ticks
    initial begin : model
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || !soft_rst) begin
                m_bits.delete();
                m_busy  = 1'b0;
                m_ticks = 0;
                e_txd   = 1'b1;
                e_done  = 1'b0;
            end else begin
                e_done = 1'b0;
                if (!m_busy) begin
                    if (tx_valid) begin
                        m_bits.push_back(1'b0);
                        for (int i = 0; i < DW; i++) m_bits.push_back(tx_data[i]);
`ifdef PP_UART_TX_PARITY_EN
                        m_bits.push_back((^tx_data) ^ parity_odd);
`endif
                        m_bits.push_back(1'b1);
                        if (stop2) m_bits.push_back(1'b1);
                        m_busy  = 1'b1;
                        m_ticks = 0;
                        e_txd   = m_bits[0];
                    end
                end else if (baud_clk) begin
                    m_ticks++;
                    if (m_ticks == OVS) begin
                        m_ticks = 0;
                        void'(m_bits.pop_front());
                        if (m_bits.size() == 0) begin
                            m_busy = 1'b0;
                            e_done = 1'b1;
                            e_txd  = 1'b1;
                        end else begin
                            e_txd = m_bits[0];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("txd", {31'b0, txd}, {31'b0, e_txd});
                check("tx_ready", {31'b0, tx_ready}, {31'b0, !m_busy});
                check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
                check("tx_done", {31'b0, tx_done}, {31'b0, e_done});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue a transfer on a cycle whose baud tick coincides with the transfer edge
    task automatic send_aligned(input logic [DW-1:0] data, input logic s2, input logic odd);
        for (int k = 0; k < 8; k++) begin
            if (baud_clk) break;
            step();
        end
        check("ready_before_send", {31'b0, tx_ready}, 32'd1);
        tx_data    = data;
        stop2      = s2;
        parity_odd = odd;
        tx_valid   = 1'b1;
        step();
        tx_valid   = 1'b0;
        tx_data    = ~data;
        stop2      = ~s2;
        parity_odd = ~odd;
    endtask

    // Send one frame, sample txd at each bit centre and time transfer-to-done
    task automatic run_frame(input string name, input logic [DW-1:0] data, input logic s2,
                             input logic odd, input int nbits, input logic [15:0] exp_bits,
                             input int exp_cycles);
        logic [15:0] got;
        int          n;
        bit          seen;
        got  = '0;
        n    = 0;
        seen = 1'b0;
        send_aligned(data, s2, odd);
        for (int off = 0; off < exp_cycles + BIT_CYC; off++) begin
            if ((off % BIT_CYC == BIT_CYC / 2) && (off / BIT_CYC < nbits)) got[off / BIT_CYC] = txd;
            if (off == exp_cycles - 1) check({name, "_ready_low"}, {31'b0, tx_ready}, 32'd0);
            if (tx_done) begin
                seen = 1'b1;
                n    = off;
                break;
            end
            step();
        end
        if (!seen) begin
            check({name, "_timeout"}, {31'b0, tx_done}, 32'd1);
        end else begin
            check({name, "_cycles"}, n, exp_cycles);
            check({name, "_bits"}, {16'b0, got}, {16'b0, exp_bits});
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while (!tx_done && k < limit) begin
            step();
            k++;
        end
        if (!tx_done) check({name, "_timeout"}, {31'b0, tx_done}, 32'd1);
    endtask

    initial begin : stim
        int cnt;
        #1;
        rst = 1'b0;
        #2;
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_busy", {31'b0, tx_busy}, 32'd0);
        check("rst_done", {31'b0, tx_done}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;
        step();

        // Single frame
        run_frame("a5", 8'hA5, 1'b0, 1'b0, NB, EXP_A5, NB * BIT_CYC);
        step();

        // Back-to-back with tx_valid held high
        tx_data  = 8'h00;
        stop2    = 1'b0;
        tx_valid = 1'b1;
        step();
        check("b2b_busy", {31'b0, tx_busy}, 32'd1);
        tx_data = 8'hFF;
        wait_done("b2b_first", 1000);
        check("b2b_ready_at_done", {31'b0, tx_ready}, 32'd1);
        check("b2b_txd_at_done", {31'b0, txd}, 32'd1);
        step();
        check("b2b_start_txd", {31'b0, txd}, 32'd0);
        check("b2b_ready_low", {31'b0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        wait_done("b2b_second", 1000);
        step();

        // Two stop bits
        run_frame("stop2", 8'h3C, 1'b1, 1'b0, NB + 1, EXP_3C, (NB + 1) * BIT_CYC);
        step();

        // Soft reset in the middle of data bit 3
        send_aligned(8'hC3, 1'b0, 1'b0);
        repeat (4 * BIT_CYC + BIT_CYC / 2) step();
        check("srst_pre_busy", {31'b0, tx_busy}, 32'd1);
        soft_rst = 1'b0;
        step();
        check("srst_txd", {31'b0, txd}, 32'd1);
        check("srst_ready", {31'b0, tx_ready}, 32'd1);
        check("srst_busy", {31'b0, tx_busy}, 32'd0);
        check("srst_done", {31'b0, tx_done}, 32'd0);
        soft_rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx_done) cnt++;
            step();
        end
        check("srst_no_done", cnt, 0);
        run_frame("after_srst", 8'h55, 1'b0, 1'b0, NB, EXP_55, NB * BIT_CYC);
        step();

        // Async reset in the stop bit, mid-cycle
        send_aligned(8'h81, 1'b0, 1'b0);
        repeat ((NB - 1) * BIT_CYC + BIT_CYC / 2) step();
        check("arst_pre_busy", {31'b0, tx_busy}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_txd", {31'b0, txd}, 32'd1);
        check("arst_ready", {31'b0, tx_ready}, 32'd1);
        check("arst_busy", {31'b0, tx_busy}, 32'd0);
        check("arst_done", {31'b0, tx_done}, 32'd0);
        step();
        rst = 1'b1;
        step();

`ifdef PP_UART_TX_PARITY_EN
        run_frame("par_even", 8'h07, 1'b0, 1'b0, 11, 16'h060E, 11 * BIT_CYC);
        step();
        run_frame("par_odd", 8'h07, 1'b0, 1'b1, 11, 16'h040E, 11 * BIT_CYC);
        step();
`endif

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
